instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 130 +++++++++++++
 tb/tb_instruction_fetch.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: credit-limited fetch unit feeding a FIFO_DEPTH-entry {instr, pc} buffer.
// Optional build macro IFETCH_RSP_BYPASS_EN forwards a response straight to the decoder when the buffer is empty.
module instruction_fetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_ifq_wr;
    logic [PTR_W-1:0] r_ifq_rd;
    logic [XLEN-1:0]  r_fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0]  r_fifo_pc    [FIFO_DEPTH];
    logic [XLEN-1:0]  r_ifq_pc     [FIFO_DEPTH];

    logic             w_credit_ok;
    logic             w_req_fire;
    logic             w_rsp_keep;
    logic             w_fifo_empty;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic [XLEN-1:0]  w_rsp_pc;

    // Buffered entries plus in-flight requests never exceed the buffer size, so every kept response has a slot.
    assign w_credit_ok    = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C;
    assign imem_req_valid = en && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_pc       = r_ifq_pc[r_ifq_rd];
    assign w_rsp_keep     = imem_rsp_valid && (r_discard == '0) && !redirect_valid;
    assign w_fifo_empty   = (r_count == '0);

`ifdef IFETCH_RSP_BYPASS_EN
    assign w_bypass = w_fifo_empty && w_rsp_keep;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_rsp_keep && !(w_bypass && instr_ready);
    assign w_pop       = !w_fifo_empty && instr_ready && !redirect_valid;

    assign instr_valid = !w_fifo_empty || w_bypass;
    assign instr       = !w_fifo_empty ? r_fifo_instr[r_rd_ptr] :
                         (w_bypass ? imem_rsp_data : '0);
    assign instr_pc    = !w_fifo_empty ? r_fifo_pc[r_rd_ptr] :
                         (w_bypass ? w_rsp_pc : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ifq_wr      <= '0;
            r_ifq_rd      <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);

            if (w_req_fire) begin
                r_ifq_wr <= r_ifq_wr + 1'b1;
            end
            // Discarded responses still retire their in-flight PC so the queue stays aligned.
            if (imem_rsp_valid) begin
                r_ifq_rd <= r_ifq_rd + 1'b1;
            end

            if (redirect_valid) begin
                r_pc      <= {redirect_pc[XLEN-1:2], 2'b00};
                r_discard <= r_outstanding - CNT_W'(imem_rsp_valid);
                r_count   <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (imem_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Storage arrays need no reset: every read is qualified by a count or a pointer.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_ifq_pc[r_ifq_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
            r_fifo_pc[r_wr_ptr]    <= w_rsp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, corner-case sequences and randomized traffic
// checked against a queue-based reference model of the fetch unit.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IFETCH_RSP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .XLEN      (XLEN),
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // memory model: in-order responses, each at least lat_min cycles after acceptance
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    cyc       = 0;
    int    lat_min   = 1;
    int    lat_max   = 1;
    int    stall_pct = 0;

    // reference model state
    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;
    logic [31:0] m_pc;
    logic [31:0] m_infl[$];
    ent_t        m_buf[$];
    int          m_discard;
    logic        e_rv, e_iv, e_byp;
    logic [31:0] e_instr, e_ipc;
    logic        a_rv;
    logic [31:0] a_addr;

    task automatic mem_drive();
        if (mq.size() > 0 && mq[0].due <= cyc && int'($urandom_range(99)) >= stall_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic model_check();
        e_rv  = en && !redirect_valid && ((m_infl.size() + m_buf.size()) < DEPTH);
        e_byp = BYP && (m_buf.size() == 0) && imem_rsp_valid && (m_discard == 0) && !redirect_valid;
        e_iv  = (m_buf.size() > 0) || e_byp;
        e_instr = '0;
        e_ipc   = '0;
        if (m_buf.size() > 0) begin
            e_instr = m_buf[0].i;
            e_ipc   = m_buf[0].p;
        end else if (e_byp) begin
            e_instr = imem_rsp_data;
            e_ipc   = (m_infl.size() > 0) ? m_infl[0] : 32'hDEAD_BEEF;
        end
        chk1("req_valid", imem_req_valid, e_rv);
        chk("req_addr", imem_req_addr, m_pc);
        chk1("instr_valid", instr_valid, e_iv);
        if (e_iv) begin
            chk("instr", instr, e_instr);
            chk("instr_pc", instr_pc, e_ipc);
        end
        a_rv   = imem_req_valid;
        a_addr = imem_req_addr;
    endtask

    task automatic model_update();
        logic [31:0] rpc;
        bit          took;
        rpc = 32'hDEAD_BEEF;
        if (imem_rsp_valid && m_infl.size() > 0) begin
            rpc = m_infl.pop_front();
        end
        if (redirect_valid) begin
            m_buf.delete();
            m_discard = m_infl.size();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            took = 1'b0;
            if (e_iv && instr_ready) begin
                if (m_buf.size() > 0) m_buf.delete(0);
                else took = 1'b1;
            end
            if (imem_rsp_valid) begin
                if (m_discard > 0) m_discard--;
                else if (!took) m_buf.push_back('{imem_rsp_data, rpc});
            end
            if (e_rv && imem_req_ready) begin
                m_infl.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic mem_update();
        int lat;
        if (imem_rsp_valid && mq.size() > 0) mq.delete(0);
        if (a_rv && imem_req_ready) begin
            lat = int'($urandom_range(lat_max, lat_min));
            mq.push_back('{a_addr, cyc + lat});
        end
        cyc++;
    endtask

    task automatic half_a();
        mem_drive();
        @(negedge clk);
        model_check();
    endtask

    task automatic half_b();
        @(posedge clk);
        model_update();
        mem_update();
        #1;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_rsp_valid = 1'b0;
        mq.delete();
        m_pc = RST_PC;
        m_infl.delete();
        m_buf.delete();
        m_discard = 0;
        @(negedge clk);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          en, rr, ir, rd;
        logic [31:0] rpc;
        bit          x_rv;
        logic [31:0] x_addr;
        bit          x_iv;
        logic [31:0] x_ipc;
    } vec_t;
    vec_t tbl[7];

    function automatic vec_t mk(input bit xrv, input logic [31:0] xa, input bit xiv, input logic [31:0] xp);
        vec_t v;
        v.en = 1'b1; v.rr = 1'b1; v.ir = 1'b1; v.rd = 1'b0; v.rpc = '0;
        v.x_rv = xrv; v.x_addr = xa; v.x_iv = xiv; v.x_ipc = xp;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          got;
        bit          seen;
        logic [31:0] ep;

`ifdef IFETCH_RSP_BYPASS_EN
        tbl[0] = mk(1'b1, 32'h00, 1'b0, 32'h00);
        tbl[1] = mk(1'b1, 32'h04, 1'b1, 32'h00);
        tbl[2] = mk(1'b1, 32'h08, 1'b1, 32'h04);
        tbl[3] = mk(1'b1, 32'h0C, 1'b1, 32'h08);
        tbl[4] = mk(1'b1, 32'h10, 1'b1, 32'h0C);
        tbl[5] = mk(1'b1, 32'h14, 1'b1, 32'h10);
        tbl[6] = mk(1'b1, 32'h18, 1'b1, 32'h14);
`else
        tbl[0] = mk(1'b1, 32'h00, 1'b0, 32'h00);
        tbl[1] = mk(1'b1, 32'h04, 1'b0, 32'h00);
        tbl[2] = mk(1'b0, 32'h08, 1'b1, 32'h00);
        tbl[3] = mk(1'b1, 32'h08, 1'b1, 32'h04);
        tbl[4] = mk(1'b1, 32'h0C, 1'b0, 32'h00);
        tbl[5] = mk(1'b0, 32'h10, 1'b1, 32'h08);
        tbl[6] = mk(1'b1, 32'h10, 1'b1, 32'h0C);
`endif

        // sequential fetch from reset, 1-cycle memory
        do_reset();
        for (int k = 0; k < 7; k++) begin
            en = tbl[k].en; imem_req_ready = tbl[k].rr; instr_ready = tbl[k].ir;
            redirect_valid = tbl[k].rd; redirect_pc = tbl[k].rpc;
            half_a();
            chk1("tbl_req_valid", imem_req_valid, tbl[k].x_rv);
            chk("tbl_req_addr", imem_req_addr, tbl[k].x_addr);
            chk1("tbl_instr_valid", instr_valid, tbl[k].x_iv);
            if (tbl[k].x_iv) begin
                chk("tbl_instr_pc", instr_pc, tbl[k].x_ipc);
                chk("tbl_instr", instr, mem_data(tbl[k].x_ipc));
            end
            half_b();
        end

        // decoder stalled for 10 cycles, then resumes
        do_reset();
        en = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            half_a();
            if (k >= 2) chk1("stall_req_valid", imem_req_valid, 1'b0);
            half_b();
        end
        instr_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 6; k++) begin
            half_a();
            if (instr_valid) begin
                ep = 32'(got) << 2;
                chk("resume_pc", instr_pc, ep);
                chk("resume_data", instr, mem_data(ep));
                got++;
            end
            half_b();
        end
        chk("resume_count", 32'(got), 32'd6);

        // redirect with two requests in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        en = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        cycle();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        half_a();
        chk1("rdr_req_valid", imem_req_valid, 1'b0);
        half_b();
        redirect_valid = 1'b0;
        half_a();
        chk1("rdr_flush_iv", instr_valid, 1'b0);
        chk("rdr_addr", imem_req_addr, 32'h0000_0100);
        half_b();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            half_a();
            if (instr_valid) begin
                chk("rdr_first_pc", instr_pc, 32'h0000_0100);
                chk("rdr_first_data", instr, mem_data(32'h0000_0100));
                seen = 1'b1;
            end
            half_b();
        end
        chk1("rdr_seen", seen, 1'b1);
        lat_min = 1; lat_max = 1;

        // memory not ready for 3 cycles
        do_reset();
        en = 1'b1; imem_req_ready = 1'b0; instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            half_a();
            chk1("hold_req_valid", imem_req_valid, 1'b1);
            chk("hold_addr", imem_req_addr, 32'h0);
            half_b();
        end
        imem_req_ready = 1'b1;
        half_a();
        chk("hold_accept_addr", imem_req_addr, 32'h0);
        half_b();
        imem_req_ready = 1'b0;
        half_a();
        chk("hold_next_addr", imem_req_addr, 32'h4);
        half_b();

        // address wrap past all-ones
        do_reset();
        en = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cycle();
        redirect_valid = 1'b0;
        half_a();
        chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        half_b();
        half_a();
        chk("wrap_addr_zero", imem_req_addr, 32'h0000_0000);
        half_b();
        got = 0;
        for (int k = 0; k < 20 && got < 2; k++) begin
            half_a();
            if (instr_valid) begin
                ep = (got == 0) ? 32'hFFFF_FFFC : 32'h0000_0000;
                chk("wrap_instr_pc", instr_pc, ep);
                got++;
            end
            half_b();
        end
        chk("wrap_count", 32'(got), 32'd2);

        // randomized traffic, including one reset mid-operation
        do_reset();
        lat_min = 1; lat_max = 4; stall_pct = 25;
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            en             = ($urandom_range(9) < 8);
            imem_req_ready = ($urandom_range(9) < 7);
            instr_ready    = ($urandom_range(9) < 7);
            redirect_valid = ($urandom_range(19) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
